// File: rtl/tlb_refill_pkg.sv
// Shared types and sizes for the TLB miss/refill path.
package tlb_pkg;
    localparam int ENTRIES = 8;
    localparam int VPN_W   = 27;
    localparam int ASID_W  = 7;
    localparam int PPN_W   = 20;
    localparam int TAG_W   = ASID_W + VPN_W;
    localparam int IDX_W   = 3;
    localparam int PLRU_W  = ENTRIES - 1;

    typedef enum logic [1:0] {
        S_READY           = 2'd0,
        S_REQUEST         = 2'd1,
        S_WAIT            = 2'd2,
        S_WAIT_INVALIDATE = 2'd3
    } state_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [ENTRIES-1:0] v);
        lowest_set = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction
endpackage

// File: rtl/tlb_refill_plru.sv
// 3-level tree pseudo-LRU for 8 ways. Node bit = 1 steers the victim to the right subtree.
module tlb_plru
    import tlb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_touch_en,
    input  logic [IDX_W-1:0] i_touch_way,
    output logic [IDX_W-1:0] o_victim
);
    logic [PLRU_W-1:0] r_tree;
    logic              w_v2, w_v1, w_v0;

    // Heap layout: node 0 is the root, nodes 1..2 level 1, nodes 3..6 level 2.
    assign w_v2 = r_tree[0];
    assign w_v1 = r_tree[3'd1 + {2'b00, w_v2}];
    assign w_v0 = r_tree[3'd3 + {1'b0, w_v2, w_v1}];
    assign o_victim = {w_v2, w_v1, w_v0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tree <= '0;
        end else if (i_touch_en) begin
            r_tree[0]                                <= ~i_touch_way[2];
            r_tree[3'd1 + {2'b00, i_touch_way[2]}]   <= ~i_touch_way[1];
            r_tree[3'd3 + {1'b0, i_touch_way[2:1]}]  <= ~i_touch_way[0];
        end
    end
endmodule

// File: rtl/tlb_refill.sv
// TLB miss handling: captures the missing VPN, drives the page-table walker and fills the victim entry.
module tlb_refill
    import tlb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic [VPN_W-1:0]  io_req_bits_vpn,
    input  logic [ASID_W-1:0] io_ptw_ptbr_asid,
    input  logic              tlb_miss,
    input  logic [ENTRIES-1:0] hits,
    output logic              io_ptw_req_valid,
    input  logic              io_ptw_req_ready,
    output logic [VPN_W-1:0]  io_ptw_req_bits_addr,
    input  logic              io_ptw_resp_valid,
    input  logic              io_ptw_resp_bits_error,
    input  logic [PPN_W-1:0]  io_ptw_resp_bits_ppn,
    input  logic              io_ptw_invalidate,
    output logic [TAG_W-1:0]  tags_0,
    output logic [TAG_W-1:0]  tags_1,
    output logic [TAG_W-1:0]  tags_2,
    output logic [TAG_W-1:0]  tags_3,
    output logic [TAG_W-1:0]  tags_4,
    output logic [TAG_W-1:0]  tags_5,
    output logic [TAG_W-1:0]  tags_6,
    output logic [TAG_W-1:0]  tags_7,
    output logic [ENTRIES-1:0] valid,
    output logic [PPN_W-1:0]  ppns_0,
    output logic [PPN_W-1:0]  ppns_1,
    output logic [PPN_W-1:0]  ppns_2,
    output logic [PPN_W-1:0]  ppns_3,
    output logic [PPN_W-1:0]  ppns_4,
    output logic [PPN_W-1:0]  ppns_5,
    output logic [PPN_W-1:0]  ppns_6,
    output logic [PPN_W-1:0]  ppns_7,
    output logic              io_resp_xcpt
);
    state_e             r_state, w_state_nxt;
    logic [TAG_W-1:0]   r_tags [ENTRIES];
    logic [PPN_W-1:0]   r_ppns [ENTRIES];
    logic [ENTRIES-1:0] r_valid;
    logic [VPN_W-1:0]   r_vpn;
    logic [TAG_W-1:0]   r_refill_tag;
    logic [IDX_W-1:0]   r_victim;
    logic               r_xcpt;

    logic               w_miss;
    logic               w_fill;
    logic               w_walk_err;
    logic               w_hit_touch;
    logic [IDX_W-1:0]   w_plru_victim;
    logic [IDX_W-1:0]   w_miss_victim;

    assign w_miss      = (r_state == S_READY) && io_req_valid && tlb_miss;
    assign w_hit_touch = (r_state == S_READY) && io_req_valid && (|hits);
    assign w_fill      = (r_state == S_WAIT) && io_ptw_resp_valid && !io_ptw_resp_bits_error;
    assign w_walk_err  = (r_state == S_WAIT) && io_ptw_resp_valid && io_ptw_resp_bits_error;
    // Empty slots are consumed first; PLRU only chooses once the array is full.
    assign w_miss_victim = (&r_valid) ? w_plru_victim : lowest_set(~r_valid);

    tlb_plru u_plru (
        .clk         (clk),
        .reset       (reset),
        .i_touch_en  (w_fill || w_hit_touch),
        .i_touch_way (w_fill ? r_victim : lowest_set(hits)),
        .o_victim    (w_plru_victim)
    );

    // A response in S_WAIT always returns to ready, even when an invalidate lands on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_READY:
                if (w_miss) w_state_nxt = S_REQUEST;
            S_REQUEST:
                if (io_ptw_req_ready)
                    w_state_nxt = io_ptw_invalidate ? S_WAIT_INVALIDATE : S_WAIT;
                else if (io_ptw_invalidate)
                    w_state_nxt = S_READY;
            S_WAIT:
                if (io_ptw_resp_valid)      w_state_nxt = S_READY;
                else if (io_ptw_invalidate) w_state_nxt = S_WAIT_INVALIDATE;
            S_WAIT_INVALIDATE:
                if (io_ptw_resp_valid) w_state_nxt = S_READY;
            default: w_state_nxt = S_READY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_READY;
            r_vpn        <= '0;
            r_refill_tag <= '0;
            r_victim     <= '0;
            r_xcpt       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_xcpt  <= w_walk_err;
            if (w_miss) begin
                r_vpn        <= io_req_bits_vpn;
                r_refill_tag <= {io_ptw_ptbr_asid, io_req_bits_vpn};
                r_victim     <= w_miss_victim;
            end
        end
    end

    // Invalidate has priority over a same-cycle fill's valid bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tags[i] <= '0;
                r_ppns[i] <= '0;
            end
        end else begin
            if (io_ptw_invalidate) r_valid <= '0;
            else if (w_fill)       r_valid[r_victim] <= 1'b1;
            if (w_fill) begin
                r_tags[r_victim] <= r_refill_tag;
                r_ppns[r_victim] <= io_ptw_resp_bits_ppn;
            end
        end
    end

    assign io_req_ready         = (r_state == S_READY);
    assign io_ptw_req_valid     = (r_state == S_REQUEST);
    assign io_ptw_req_bits_addr = r_vpn;
    assign io_resp_xcpt         = r_xcpt;
    assign valid                = r_valid;

    assign tags_0 = r_tags[0];
    assign tags_1 = r_tags[1];
    assign tags_2 = r_tags[2];
    assign tags_3 = r_tags[3];
    assign tags_4 = r_tags[4];
    assign tags_5 = r_tags[5];
    assign tags_6 = r_tags[6];
    assign tags_7 = r_tags[7];
    assign ppns_0 = r_ppns[0];
    assign ppns_1 = r_ppns[1];
    assign ppns_2 = r_ppns[2];
    assign ppns_3 = r_ppns[3];
    assign ppns_4 = r_ppns[4];
    assign ppns_5 = r_ppns[5];
    assign ppns_6 = r_ppns[6];
    assign ppns_7 = r_ppns[7];
endmodule
